seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Multiplexed multi-digit 7-segment display driver, parametrised in digit count, scan rate and output polarity. It latches a packed hex word into a shadow register and scans it onto one shared segment bus, one digit at a time, with a per-digit enable. Each digit shows the full 0–F glyph set. Optional leading-zero blanking is available. It sits between datapath/counter logic and the board's common-segment display pins, and supersedes the single-digit combinational decoder.

## Interface
- NUM_DIGITS, 4: number of digits scanned; 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- ACTIVE_LOW, 1: 1 = segment, dp and digit-enable pins are active-low; 0 = active-high.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  packed hex digits; digit k = value[4k+3:4k]; digit 0 is least significant and rightmost.
- dp_in  input  NUM_DIGITS  decimal-point request per digit; bit k drives digit k.
- load  input  1  single-cycle strobe; captures value and dp_in into the shadow registers.
- blank_in  input  1  level; forces all digits dark while high; scanning continues.
- seg_out  output  7  segments {g,f,e,d,c,b,a}; bit 0 = a.
- dp_out  output  1  decimal point of the currently scanned digit.
- digit_en  output  NUM_DIGITS  one-hot (or all-inactive) digit select.
- scan_tick  output  1  one-cycle pulse each time the digit index advances.

## Operation
- State:
  - prescaler cnt, 0..SCAN_DIV-1;
  - digit index idx, 0..NUM_DIGITS-1;
  - shadow_val and shadow_dp.
- Prescaler: cnt increments every cycle. At SCAN_DIV-1 it wraps to 0, and idx advances at the same edge. idx wraps from NUM_DIGITS-1 to 0.
- load=1 at an edge copies value and dp_in into the shadow registers. The display reads only the shadow registers, so a mid-scan change on value never tears.
- load and an idx advance at the same edge: both take effect.
- Decode (gfedcba, active-high form; inverted when ACTIVE_LOW=1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Blank glyph: all segments off, dp off. It is used when blank_in=1 or when the digit is suppressed (see Configuration).
- Ghost guard: digit_en is all-inactive during any cycle whose source state has cnt==0. This gives one dark cycle per slot and avoids segment bleed during the digit switch.
- Otherwise digit_en has exactly bit idx active. blank_in does not gate digit_en; it gates segments and dp only.

## Timing
- All outputs are registered. Outputs in cycle t+1 are a function of cnt, idx, shadow_val, shadow_dp and blank_in in cycle t (1-cycle latency).
- scan_tick is high in the cycle after the edge at which idx advanced.
- Reset (while reset=1 and the first cycle after release):
  - cnt=0, idx=0, shadow_val=0, shadow_dp=0;
  - seg_out = all off (7'h7F if ACTIVE_LOW, else 7'h00);
  - dp_out off, digit_en all inactive, scan_tick=0.
- Reset has priority over load. Reset mid-scan returns the block to idx 0 and cnt 0 with no partial slot.
- Full scan period = NUM_DIGITS*SCAN_DIV cycles. Each digit is enabled for SCAN_DIV-1 cycles per period.
- load → new glyph visible: at most 2 cycles if that digit is currently scanned, otherwise at its next slot.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking.
  - Digit k (k>0) shows the blank glyph if it and every higher digit in shadow_val are 0.
  - Digit 0 always shows its glyph.
  - dp_in for a suppressed digit still lights dp_out.
- SEVSEG_LZB_EN undefined: every digit always shows its glyph.

## Test plan
Unless noted, NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset: hold reset 3 cycles, then release → seg_out=7'h7F, digit_en=4'hF, scan_tick=0 during reset and the first cycle after. From then on, idx sequence 0,1,2,3,0 with a 4-cycle slot; scan_tick pulses every 4 cycles.
- Decode sweep: NUM_DIGITS=1; load 0x0..0xF one per 8 cycles → seg_out matches the inverted table for every value, e.g. 0x0→7'h40, 0xA→7'h08, 0xF→7'h0E.
- Tear-free load: load 0x1234; change value to 0xFFFF without load → all digits still show 4,3,2,1. Pulse load → 0xFFFF appears at the next digit-0 slot.
- Ghost guard and dp: dp_in=4'b0100 → digit_en is inactive for the first cycle of every slot; dp_out is active only in digit-2 slots.
- blank_in=1 for a full scan period → seg_out=7'h7F and dp off throughout, while digit_en keeps scanning. Deasserting blank_in restores glyphs within 1 cycle.
- With SEVSEG_LZB_EN defined, load 0x0050 → digits 3 and 2 blank, digit 1 shows "5", digit 0 shows "0". Load 0x0000 → only digit 0 shows "0". Reset asserted mid-slot during this test returns to idx 0 and blanked outputs.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed N-digit hex 7-segment scanner with shadow latch.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_in,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    scan_tick
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam bit INV = (ACTIVE_LOW != 0);
   localparam logic [6:0] SEG_OFF = INV ? 7'h7F : 7'h00;
   localparam logic DP_OFF = INV;
   localparam logic [NUM_DIGITS-1:0] EN_OFF =
      INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   // Active-high gfedcba glyphs for the full hex set.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic                    scan_tick_q, scan_tick_d;

   logic                    wrap;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_lz;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [NUM_DIGITS-1:0]   en_raw;
   logic [6:0]              seg_raw;
   logic                    dp_raw;
   logic                    suppress;

   // Prescaler and digit index; the index steps when the prescaler wraps.
   always_comb begin
      wrap  = (cnt_q == CNT_LAST);
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (wrap) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // Shadow registers isolate the display from mid-scan changes on value.
   always_comb begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_in;
      end
   end

`ifdef SEVSEG_LZB_EN
   logic lz_run;

   // Digit k>0 goes dark when it and every higher digit are zero.
   always_comb begin
      lz_mask = '0;
      lz_run  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         lz_run     = lz_run & (shadow_val_q[4*k +: 4] == 4'h0);
         lz_mask[k] = lz_run;
      end
   end
`else
   // Every digit always shows its glyph.
   always_comb begin
      lz_mask = '0;
   end
`endif

   // Select the nibble, dp and blanking flag of the digit being scanned.
   always_comb begin
      cur_nib = '0;
      cur_dp  = 1'b0;
      cur_lz  = 1'b0;
      en_raw  = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_nib   = shadow_val_q[4*k +: 4];
            cur_dp    = shadow_dp_q[k];
            cur_lz    = lz_mask[k];
            en_raw[k] = (cnt_q != '0);
         end
      end
   end

   // Next registered outputs; cnt==0 keeps digits dark to avoid bleed.
   always_comb begin
      suppress    = blank_in | cur_lz;
      seg_raw     = suppress ? 7'h00 : glyph(cur_nib);
      dp_raw      = ~blank_in & cur_dp;
      seg_d       = INV ? ~seg_raw : seg_raw;
      dp_d        = INV ? ~dp_raw : dp_raw;
      digit_en_d  = INV ? ~en_raw : en_raw;
      scan_tick_d = wrap;
   end

   // State and output registers; reset wins over load.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         digit_en_q   <= EN_OFF;
         scan_tick_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         digit_en_q   <= digit_en_d;
         scan_tick_q  <= scan_tick_d;
      end
   end

   assign seg_out   = seg_q;
   assign dp_out    = dp_q;
   assign digit_en  = digit_en_q;
   assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: reference model feeds a queue,
// a negedge monitor pops and compares every cycle.
module tb_seven_seg_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;
`ifdef SEVSEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] en;
      logic       tick;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        blank_in = 1'b0;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  digit_en;
   logic        scan_tick;

   int n_tests = 0;
   int n_fail = 0;
   int ticks = 0;

   exp_t exp_q[$];

   int          m_cnt = 0;
   int          m_idx = 0;
   logic [15:0] m_val = '0;
   logic [3:0]  m_dp = '0;

   seven_seg_scan_driver #(
      .NUM_DIGITS(ND),
      .SCAN_DIV(SD),
      .ACTIVE_LOW(1)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .value(value),
      .dp_in(dp_in),
      .load(load),
      .blank_in(blank_in),
      .seg_out(seg_out),
      .dp_out(dp_out),
      .digit_en(digit_en),
      .scan_tick(scan_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_glyph(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   function automatic bit ref_lz(input int k, input logic [15:0] v);
      return LZB && (k != 0) && ((v >> (4 * k)) == 16'h0);
   endfunction

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req,
                  $time);
      end
   endtask

   // Reference model: expected registered outputs for the coming cycle.
   always @(posedge clk) begin
      exp_t e;
      logic [6:0] s;
      logic       d;
      logic [3:0] en;
      bit         sup;
      if (reset) begin
         e.seg = 7'h7F;
         e.dp = 1'b1;
         e.en = 4'hF;
         e.tick = 1'b0;
         exp_q.push_back(e);
         m_cnt = 0;
         m_idx = 0;
         m_val = '0;
         m_dp = '0;
      end else begin
         sup = blank_in || ref_lz(m_idx, m_val);
         s = sup ? 7'h00 : ref_glyph(m_val[m_idx*4 +: 4]);
         d = !blank_in && m_dp[m_idx];
         en = (m_cnt == 0) ? 4'h0 : 4'(1 << m_idx);
         e.seg = ~s;
         e.dp = ~d;
         e.en = ~en;
         e.tick = (m_cnt == SD - 1);
         exp_q.push_back(e);
         if (load) begin
            m_val = value;
            m_dp = dp_in;
         end
         if (m_cnt == SD - 1) begin
            m_cnt = 0;
            m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
         end else begin
            m_cnt++;
         end
      end
   end

   // Monitor: every cycle is an output beat.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("seg_out", {1'b0, seg_out}, {1'b0, e.seg});
         chk("dp_out", {7'b0, dp_out}, {7'b0, e.dp});
         chk("digit_en", {4'b0, digit_en}, {4'b0, e.en});
         chk("scan_tick", {7'b0, scan_tick}, {7'b0, e.tick});
      end
      if (scan_tick === 1'b1) ticks++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   initial begin
      int t0;
      cyc(2);
      @(negedge clk);
      #1;
      chk("rst_seg", {1'b0, seg_out}, 8'h7F);
      chk("rst_en", {4'b0, digit_en}, 8'h0F);
      chk("rst_tick", {7'b0, scan_tick}, 8'h00);
      cyc(1);
      reset = 1'b0;
      cyc(10);
      t0 = ticks;
      cyc(32);
      chk("tick_rate", 8'(ticks - t0), 8'd8);

      do_load(16'h3210, 4'h0);
      cyc(16);
      do_load(16'h7654, 4'h0);
      cyc(16);
      do_load(16'hBA98, 4'h0);
      cyc(16);
      do_load(16'hFEDC, 4'h0);
      cyc(16);

      do_load(16'h1234, 4'h0);
      cyc(16);
      value = 16'hFFFF;
      cyc(16);
      do_load(16'hFFFF, 4'h0);
      cyc(16);

      do_load(16'h1234, 4'b0100);
      cyc(16);

      blank_in = 1'b1;
      cyc(16);
      blank_in = 1'b0;
      cyc(8);

      do_load(16'h0050, 4'b0000);
      cyc(16);
      do_load(16'h0000, 4'b1000);
      cyc(6);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(12);

      cyc(3);
      do_load(16'hA0C1, 4'b1011);
      cyc(20);

      @(negedge clk);
      #1;
      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
